mips_cpu_pc_unit: RTL and testbench

//  Program-counter unit of the MIPS CPU: holds the 32-bit PC, advances it by 4 per executed

---
 rtl/mips_cpu_pkg.sv | 36 +++
 rtl/mips_cpu_pc_branch_decode.sv | 50 +++++
 rtl/mips_cpu_pc_unit.sv | 76 +++++++
 tb/tb_mips_cpu_pc_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU constants: opcode/funct/REGIMM encodings, reset vector,
// compare-flag bit positions and the PC redirect target selector.
package mips_cpu_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FUNCT_JR   = 6'b001000;
  localparam logic [5:0] FUNCT_JALR = 6'b001001;

  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;
  localparam logic [4:0] RT_BLTZAL  = 5'b10000;
  localparam logic [4:0] RT_BGEZAL  = 5'b10001;

  // Bit positions inside the {rs==rt, rs>0, rs==0, rs<0} compare bus
  localparam int CMP_EQ  = 3;
  localparam int CMP_GTZ = 2;
  localparam int CMP_EQZ = 1;
  localparam int CMP_LTZ = 0;

  typedef enum logic [1:0] {
    TGT_BRANCH = 2'd0,
    TGT_JUMP   = 2'd1,
    TGT_REG    = 2'd2
  } tgt_sel_e;

endpackage

// File: rtl/mips_cpu_pc_branch_decode.sv
// Combinational jump/branch decode: decides whether the instruction at pc
// redirects control flow and which target source the redirect uses.
module mips_cpu_pc_branch_decode
  import mips_cpu_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic [4:0] i_rt,
  input  logic [4:0] i_sa,
  input  logic [4:0] i_rd,
  input  logic [3:0] i_control,
  output logic       o_taken,
  output logic [1:0] o_sel
);

  logic w_jr_ok;
  logic w_jalr_ok;

  // Malformed register jumps fall through as ordinary sequential instructions
  assign w_jr_ok   = (i_funct == FUNCT_JR) && (i_rt == 5'd0) && (i_sa == 5'd0) && (i_rd == 5'd0);
  assign w_jalr_ok = (i_funct == FUNCT_JALR) && (i_rt == 5'd0) && (i_sa == 5'd0);

  always_comb begin
    o_taken = 1'b0;
    o_sel   = TGT_BRANCH;
    case (i_opcode)
      OP_J, OP_JAL: begin
        o_taken = 1'b1;
        o_sel   = TGT_JUMP;
      end
      OP_SPECIAL: begin
        o_sel   = TGT_REG;
        o_taken = w_jr_ok || w_jalr_ok;
      end
      OP_BEQ:  o_taken = i_control[CMP_EQ];
      OP_BNE:  o_taken = !i_control[CMP_EQ];
      OP_BLEZ: o_taken = i_control[CMP_EQZ] || i_control[CMP_LTZ];
      OP_BGTZ: o_taken = i_control[CMP_GTZ];
      OP_REGIMM: begin
        case (i_rt)
          RT_BLTZ, RT_BLTZAL: o_taken = i_control[CMP_LTZ];
          RT_BGEZ, RT_BGEZAL: o_taken = !i_control[CMP_LTZ];
          default:            o_taken = 1'b0;
        endcase
      end
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_cpu_pc_unit.sv
// MIPS program counter with one architectural delay slot: a taken jump or
// branch is latched as a pending redirect and applied one instruction later.
module mips_cpu_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = mips_cpu_pkg::RESET_VECTOR
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_waitrequest,
  input  logic [5:0]  i_opcode,
  input  logic [5:0]  i_funct,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_sa,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_rs_data,
  input  logic [15:0] i_offset,
  input  logic [25:0] i_target,
  input  logic [3:0]  i_control,
  output logic [31:0] o_pc,
  output logic [31:0] o_regstore
);
  import mips_cpu_pkg::*;

  logic [31:0] r_pc;
  logic        r_pending;
  logic [31:0] r_pending_target;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;
  logic [31:0] w_redirect_target;
  logic        w_taken;
  logic [1:0]  w_sel;

  mips_cpu_pc_branch_decode u_decode (
    .i_opcode  (i_opcode),
    .i_funct   (i_funct),
    .i_rt      (i_rt),
    .i_sa      (i_sa),
    .i_rd      (i_rd),
    .i_control (i_control),
    .o_taken   (w_taken),
    .o_sel     (w_sel)
  );

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_branch_target = w_pc_plus4 + {{14{i_offset[15]}}, i_offset, 2'b00};
  assign w_jump_target   = {w_pc_plus4[31:28], i_target, 2'b00};

  always_comb begin
    w_redirect_target = w_branch_target;
    if (w_sel == TGT_JUMP) begin
      w_redirect_target = w_jump_target;
    end else if (w_sel == TGT_REG) begin
      w_redirect_target = i_rs_data;
    end
  end

  // A jump in a delay slot both consumes the older redirect and latches its own
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc             <= RESET_VECTOR;
      r_pending        <= 1'b0;
      r_pending_target <= 32'd0;
    end else if (!i_waitrequest) begin
      r_pc      <= r_pending ? r_pending_target : w_pc_plus4;
      r_pending <= w_taken;
      if (w_taken) begin
        r_pending_target <= w_redirect_target;
      end
    end
  end

  assign o_pc       = r_pc;
  assign o_regstore = r_pc + 32'd8;

endmodule

// File: tb/tb_mips_cpu_pc_unit.sv
// Bench for mips_cpu_pc_unit: directed delay-slot scenarios with literal
// expectations, then randomized instruction streams against a reference model.
module tb_mips_cpu_pc_unit;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'b100000;
  logic [4:0]  rt = 5'd0;
  logic [4:0]  sa = 5'd0;
  logic [4:0]  rd = 5'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic [15:0] offset = 16'd0;
  logic [25:0] target = 26'd0;
  logic [3:0]  control;
  logic [31:0] pc;
  logic [31:0] regstore;

  always #5 clk = ~clk;

  // Compare flags as the register file would derive them from the two operands
  assign control = {rs_val == rt_val, $signed(rs_val) > 0, rs_val == 32'd0, $signed(rs_val) < 0};

  mips_cpu_pc_unit #(.RESET_VECTOR(RV)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_waitrequest (wr),
    .i_opcode      (opcode),
    .i_funct       (funct),
    .i_rt          (rt),
    .i_sa          (sa),
    .i_rd          (rd),
    .i_rs_data     (rs_val),
    .i_offset      (offset),
    .i_target      (target),
    .i_control     (control),
    .o_pc          (pc),
    .o_regstore    (regstore)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  bit          cmp_en = 1'b0;
  bit          lit_req = 1'b0;
  logic [31:0] lit_exp = 32'd0;
  string       lit_name = "";

  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_tgt;
  logic [32:0] m_dec;

  // Returns {redirect, target} for the instruction currently presented at cur_pc
  function automatic logic [32:0] ref_decode(input logic [31:0] cur_pc);
    logic [31:0] seq;
    logic [31:0] br;
    int          soff;
    int          s_rs;
    soff = $signed(offset);
    s_rs = $signed(rs_val);
    seq  = cur_pc + 32'd4;
    br   = seq + 32'(soff * 4);
    case (opcode)
      6'd2, 6'd3: return {1'b1, seq[31:28], target, 2'b00};
      6'd0: if (((funct == 6'd8 && rd == 5'd0) || funct == 6'd9) && rt == 5'd0 && sa == 5'd0)
              return {1'b1, rs_val};
      6'd4: if (rs_val == rt_val) return {1'b1, br};
      6'd5: if (rs_val != rt_val) return {1'b1, br};
      6'd6: if (s_rs <= 0) return {1'b1, br};
      6'd7: if (s_rs > 0) return {1'b1, br};
      6'd1: if (((rt == 5'd0 || rt == 5'd16) && s_rs < 0) ||
                ((rt == 5'd1 || rt == 5'd17) && s_rs >= 0))
              return {1'b1, br};
      default: ;
    endcase
    return {1'b0, 32'd0};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc   = RV;
      m_pend = 1'b0;
      m_tgt  = 32'd0;
    end else if (!wr) begin
      m_dec = ref_decode(m_pc);
      m_pc  = m_pend ? m_tgt : m_pc + 32'd4;
      if (m_dec[32]) begin
        m_pend = 1'b1;
        m_tgt  = m_dec[31:0];
      end else begin
        m_pend = 1'b0;
      end
    end
  end

  // Single compare process: model check every cycle plus requested literal checks
  always @(negedge clk) begin
    if (cmp_en) begin
      n_checks++;
      if (pc !== m_pc || regstore !== m_pc + 32'd8) begin
        n_errors++;
        $display("FAIL model_cmp t=%0t pc=%h regstore=%h expected pc=%h regstore=%h",
                 $time, pc, regstore, m_pc, m_pc + 32'd8);
      end
    end
    if (lit_req) begin
      n_checks++;
      if (pc !== lit_exp || regstore !== lit_exp + 32'd8) begin
        n_errors++;
        $display("FAIL %s pc=%h regstore=%h expected pc=%h regstore=%h",
                 lit_name, pc, regstore, lit_exp, lit_exp + 32'd8);
      end else begin
        $display("ok %s pc=%h regstore=%h", lit_name, pc, regstore);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input string name, input logic [31:0] exp);
    lit_name = name;
    lit_exp  = exp;
    lit_req  = 1'b1;
    @(negedge clk);
    #1;
    lit_req  = 1'b0;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt_i,
                       input logic [4:0] sa_i, input logic [4:0] rd_i, input logic [15:0] off,
                       input logic [25:0] tgt, input logic [31:0] rsv, input logic [31:0] rtv);
    opcode = op; funct = fn; rt = rt_i; sa = sa_i; rd = rd_i;
    offset = off; target = tgt; rs_val = rsv; rt_val = rtv;
  endtask

  task automatic drive_add();
    drive(6'd0, 6'b100000, 5'd3, 5'd0, 5'd4, 16'h1234, 26'h0, 32'd7, 32'd9);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_random();
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rsel;
    a = pick_val();
    b = ($urandom_range(0, 1) == 0) ? a : pick_val();
    drive_add();
    rs_val = a; rt_val = b;
    offset = 16'($urandom); target = 26'($urandom);
    case ($urandom_range(0, 10))
      0: drive_add();
      1: opcode = 6'd2;
      2: opcode = 6'd3;
      3, 4: begin
        opcode = 6'd0;
        funct  = ($urandom_range(0, 1) == 0) ? 6'd8 : 6'd9;
        rs_val = $urandom;
        rt = 5'd0; sa = 5'd0; rd = 5'd0;
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 2))
            0: rt = 5'($urandom_range(1, 31));
            1: sa = 5'($urandom_range(1, 31));
            default: rd = 5'($urandom_range(1, 31));
          endcase
        end
      end
      5: opcode = 6'd4;
      6: opcode = 6'd5;
      7: opcode = 6'd6;
      8: opcode = 6'd7;
      9: begin
        opcode = 6'd1;
        rsel = 5'($urandom_range(0, 4));
        case (rsel)
          5'd0: rt = 5'd0;
          5'd1: rt = 5'd1;
          5'd2: rt = 5'd16;
          5'd3: rt = 5'd17;
          default: rt = 5'($urandom);
        endcase
      end
      default: opcode = 6'($urandom_range(8, 63));
    endcase
  endtask

  initial begin
    drive_add();
    rst_n = 1'b0;
    tick();
    cmp_en = 1'b1;
    expect_pc("reset_c1", RV);
    tick();
    expect_pc("reset_c2", RV);
    tick();
    expect_pc("reset_c3", RV);
    rst_n = 1'b1;
    tick();
    expect_pc("add_step1", 32'hBFC0_0004);
    tick();
    expect_pc("add_step2", 32'hBFC0_0008);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_pc("rereset", RV);
    drive(6'd2, 6'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h1557FD5, 32'd0, 32'd0);
    tick();
    expect_pc("j_delay_slot", 32'hBFC0_0004);
    drive_add();
    tick();
    expect_pc("j_target", 32'hB555_FF54);
    tick();
    expect_pc("j_resume", 32'hB555_FF58);

    drive(6'd4, 6'd0, 5'd0, 5'd0, 5'd0, 16'hFFFF, 26'd0, 32'd5, 32'd5);
    tick();
    expect_pc("beq_t_slot", 32'hB555_FF5C);
    drive_add();
    tick();
    expect_pc("beq_t_target", 32'hB555_FF58);
    drive(6'd4, 6'd0, 5'd0, 5'd0, 5'd0, 16'hFFFF, 26'd0, 32'd5, 32'd6);
    tick();
    expect_pc("beq_nt_slot", 32'hB555_FF5C);
    drive_add();
    tick();
    expect_pc("beq_nt_next", 32'hB555_FF60);

    drive(6'd0, 6'd8, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 32'h8000_0010, 32'd0);
    tick();
    expect_pc("jr_slot", 32'hB555_FF64);
    drive_add();
    tick();
    expect_pc("jr_target", 32'h8000_0010);
    drive(6'd0, 6'd8, 5'd0, 5'd1, 5'd0, 16'd0, 26'd0, 32'h8000_0010, 32'd0);
    tick();
    expect_pc("jr_bad_sa1", 32'h8000_0014);
    drive_add();
    tick();
    expect_pc("jr_bad_sa2", 32'h8000_0018);

    drive(6'd2, 6'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 32'd0, 32'd0);
    tick();
    expect_pc("wr_slot", 32'h8000_001C);
    drive_add();
    wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_pc("wr_frozen", 32'h8000_001C);
    end
    wr = 1'b0;
    tick();
    expect_pc("wr_redirect", 32'h8000_0000);

    drive(6'd4, 6'd0, 5'd0, 5'd0, 5'd0, 16'd4, 26'd0, 32'd3, 32'd3);
    tick();
    expect_pc("rst_pend_slot", 32'h8000_0004);
    drive_add();
    #1;
    rst_n = 1'b0;
    expect_pc("rst_async", RV);
    tick();
    rst_n = 1'b1;
    tick();
    expect_pc("rst_discard", 32'hBFC0_0004);

    drive(6'd0, 6'd9, 5'd0, 5'd0, 5'd7, 16'd0, 26'd0, 32'hFFFF_FFFC, 32'd0);
    tick();
    expect_pc("jalr_slot", 32'hBFC0_0008);
    drive_add();
    tick();
    expect_pc("jalr_top", 32'hFFFF_FFFC);
    tick();
    expect_pc("wrap_zero", 32'h0000_0000);

    for (int n = 0; n < 3000; n++) begin
      drive_random();
      wr = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
